yc_chroma_decoder: RTL and testbench
====================================

// Module: yc_chroma_decoder
// PURPOSE
// - Receive-side counterpart of the S-Video/composite Y/C encoder: takes sampled Y and C (C offset by VREF).
// - Locks to the colourburst phase each line and demodulates C into signed U/V.
// - Sits in the clk50 domain after the capture ADC; feeds the YUV->RGB stage / test monitors.
// PARAMETERS
// VREF         100  C DC level; c_s = c_in - VREF (signed 9b)
// SPC          14   samples per subcarrier cycle; fixed, LUT depth
// BURST_START  45   first burst sample (line_cnt)
// BURST_END    175  last burst sample (line_cnt)
// ACTIVE_START 176  first demodulated sample (line_cnt)
// LOCK_MIN     6    min consistent burst zero-crossings for lock
// OUT_SHIFT    10   arithmetic right shift of accumulators before saturation
// PORTS
// clk       in   1   sample clock (clk50 domain)
// reset_n   in   1   asynchronous, active-low reset
// hsync     in   1   active-high horizontal sync
// y_in      in   8   luma sample
// c_in      in   8   chroma sample, unsigned, centred on VREF
// y_out     out  8   luma, y_in delayed 2 cycles
// u_out     out  8   signed U, saturated to [-128,127]
// v_out     out  8   signed V, saturated to [-128,127]
// uv_valid  out  1   1-cycle pulse when u_out/v_out update
// locked    out  1   burst phase lock status of the last burst
// BEHAVIOUR
// - Reset (async, reset_n=0): all outputs 0, phase_off=0, state=SYNC, counters 0, accumulators 0.
// - line_cnt 9b: held 0 while hsync=1, else +1 per clk, saturates at 511.
// - k_cnt 0..13: held 0 while hsync=1, else increments, wraps 13->0.
// - FSM: SYNC -> PORCH (hsync=0) -> BURST (line_cnt==BURST_START) -> WAIT (line_cnt>BURST_END)
//   -> ACTIVE (line_cnt==ACTIVE_START). hsync=1 in any state -> SYNC next cycle.
// - Zero-crossing detection in BURST only: rising crossing = c_s_prev<0 && c_s>=0.
//   - First crossing: zc_idx<=k_cnt, zc_cnt<=1.
//   - Later crossings: k_cnt==zc_idx -> zc_cnt++ (sat 15); otherwise zc_bad<=1.
//   - zc_cnt, zc_bad and first-crossing flag are cleared on entry to BURST.
// - On BURST->WAIT:
//   - !zc_bad && zc_cnt>=LOCK_MIN: phase_off<=zc_idx, locked<=1.
//   - else: locked<=0, phase_off held.
//   - locked is otherwise stable across the line.
// - Demod index: d = (k_cnt + SPC - phase_off) mod SPC.
//   - LUT sin[d]=round(256*sin(2*pi*d/14)), cos[d]=round(256*cos(2*pi*d/14)), signed 10b.
// - ACTIVE:
//   - acc_u += c_s*sin[d]; acc_v += c_s*cos[d].
//   - Products 19b signed; accumulators 24b signed.
//   - Accumulators load the product (not add) when d==0.
//   - On the sample with d==13, the next cycle: u_out/v_out <= sat8(acc>>>OUT_SHIFT) including that sample, uv_valid=1.
//   - If locked=0: u_out=v_out=0 at update; uv_valid still pulses.
//   - First window starts at the first d==0 in ACTIVE; samples before it are discarded.
// - hsync mid-ACTIVE: partial window discarded, no uv_valid; u_out/v_out hold their last values.
// - u_out/v_out hold between updates.
// - y_out always 2-cycle delay, independent of FSM.
// TESTING
// - Reset: reset_n=0 mid-line -> all outputs 0 immediately (async). After release, locked=0 until a valid burst.
// - Lock: burst c_in=100+round(30*sin(2*pi*(k-3)/14)) over BURST window -> locked=1, phase_off=3 at BURST end.
// - U demod: after lock, active c_in=100+round(20*sin(2*pi*(k-3)/14)).
//   -> u_out=35+/-2, v_out=0+/-2; uv_valid every 14 clk.
// - V demod: same, using cos -> v_out=35+/-2, u_out=0+/-2. A=80 -> saturates u_out or v_out at 127.
// - No burst: c_in=100 constant in burst -> locked=0; u_out=v_out=0 at every uv_valid.
//   Next good burst -> relock.
// - Truncation: hsync=1 at the 7th sample of a window -> no uv_valid for it, outputs hold.
//   Inconsistent crossings (jittered burst) -> locked=0.

Source files
------------

// File: rtl/yc_chroma_decoder.sv
// Y/C chroma decoder: locks to the colourburst phase each line and demodulates
// the offset chroma into saturated signed U/V, one pair per subcarrier cycle.
module yc_chroma_decoder #(
    parameter int DATA_W       = 8,
    parameter int COEF_W       = 10,
    parameter int VREF         = 100,
    parameter int SPC          = 14,
    parameter int BURST_START  = 45,
    parameter int BURST_END    = 175,
    parameter int ACTIVE_START = 176,
    parameter int LOCK_MIN     = 6,
    parameter int OUT_SHIFT    = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     hsync,
    input  logic        [DATA_W-1:0] y_in,
    input  logic        [DATA_W-1:0] c_in,
    output logic        [DATA_W-1:0] y_out,
    output logic signed [DATA_W-1:0] u_out,
    output logic signed [DATA_W-1:0] v_out,
    output logic                     uv_valid,
    output logic                     locked
);

    localparam int CS_W   = DATA_W + 1;
    localparam int PROD_W = CS_W + COEF_W;
    localparam int ACC_W  = 24;

    localparam logic [8:0] LINE_MAX = 9'd511;
    localparam logic [8:0] B_START  = 9'(BURST_START);
    localparam logic [8:0] B_END    = 9'(BURST_END);
    localparam logic [8:0] A_START  = 9'(ACTIVE_START);
    localparam logic [3:0] K_LAST   = 4'(SPC - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_MIN);
    localparam logic [4:0] SPC_5    = 5'(SPC);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [2:0] {SYNC, PORCH, BURST, WAIT, ACTIVE} state_t;

    state_t                     state;
    logic        [8:0]          line_cnt, line_nxt;
    logic        [3:0]          k_cnt, phase_off, zc_idx, zc_cnt, d;
    logic        [4:0]          d_raw;
    logic                       zc_bad, zc_seen, zc_rise, demod_en, win_act;
    logic signed [CS_W-1:0]     c_s, c_s_prev;
    logic signed [COEF_W-1:0]   sin_c, cos_c;
    logic signed [PROD_W-1:0]   prod_u, prod_v;
    logic signed [ACC_W-1:0]    acc_u, acc_v, acc_u_nxt, acc_v_nxt;
    logic        [DATA_W-1:0]   y_p0;

    function automatic logic signed [COEF_W-1:0] sin_lut(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd6:   sin_lut = COEF_W'(111);
            4'd2, 4'd5:   sin_lut = COEF_W'(200);
            4'd3, 4'd4:   sin_lut = COEF_W'(250);
            4'd8, 4'd13:  sin_lut = -COEF_W'(111);
            4'd9, 4'd12:  sin_lut = -COEF_W'(200);
            4'd10, 4'd11: sin_lut = -COEF_W'(250);
            default:      sin_lut = '0;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] cos_lut(input logic [3:0] idx);
        case (idx)
            4'd0:         cos_lut = COEF_W'(256);
            4'd1, 4'd13:  cos_lut = COEF_W'(231);
            4'd2, 4'd12:  cos_lut = COEF_W'(160);
            4'd3, 4'd11:  cos_lut = COEF_W'(57);
            4'd4, 4'd10:  cos_lut = -COEF_W'(57);
            4'd5, 4'd9:   cos_lut = -COEF_W'(160);
            4'd6, 4'd8:   cos_lut = -COEF_W'(231);
            4'd7:         cos_lut = -COEF_W'(256);
            default:      cos_lut = '0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_MAX)      sat_out = SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN) sat_out = SAT_MIN[DATA_W-1:0];
        else                  sat_out = s[DATA_W-1:0];
    endfunction

    assign line_nxt = (line_cnt == LINE_MAX) ? LINE_MAX : line_cnt + 9'd1;
    assign c_s      = signed'({1'b0, c_in}) - CS_W'(VREF);
    assign zc_rise  = c_s_prev[CS_W-1] && !c_s[CS_W-1];

    // Demod phase relative to the locked burst phase
    assign d_raw     = {1'b0, k_cnt} + SPC_5 - {1'b0, phase_off};
    assign d         = (d_raw >= SPC_5) ? 4'(d_raw - SPC_5) : d_raw[3:0];
    assign sin_c     = sin_lut(d);
    assign cos_c     = cos_lut(d);
    assign prod_u    = c_s * sin_c;
    assign prod_v    = c_s * cos_c;
    assign acc_u_nxt = (d == 4'd0) ? {{(ACC_W-PROD_W){prod_u[PROD_W-1]}}, prod_u}
                                   : acc_u + {{(ACC_W-PROD_W){prod_u[PROD_W-1]}}, prod_u};
    assign acc_v_nxt = (d == 4'd0) ? {{(ACC_W-PROD_W){prod_v[PROD_W-1]}}, prod_v}
                                   : acc_v + {{(ACC_W-PROD_W){prod_v[PROD_W-1]}}, prod_v};
    assign demod_en  = (state == ACTIVE) && !hsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SYNC;
            line_cnt  <= '0;
            k_cnt     <= '0;
            phase_off <= '0;
            locked    <= 1'b0;
            zc_idx    <= '0;
            zc_cnt    <= '0;
            zc_bad    <= 1'b0;
            zc_seen   <= 1'b0;
        end else if (hsync) begin
            state    <= SYNC;
            line_cnt <= '0;
            k_cnt    <= '0;
        end else begin
            line_cnt <= line_nxt;
            k_cnt    <= (k_cnt == K_LAST) ? 4'd0 : k_cnt + 4'd1;
            case (state)
                SYNC:  state <= PORCH;
                PORCH: if (line_nxt == B_START) begin
                    state   <= BURST;
                    zc_cnt  <= '0;
                    zc_bad  <= 1'b0;
                    zc_seen <= 1'b0;
                end
                BURST: if (line_nxt > B_END) begin
                    state <= WAIT;
                    if (!zc_bad && zc_cnt >= LOCK_N) begin
                        phase_off <= zc_idx;
                        locked    <= 1'b1;
                    end else begin
                        locked <= 1'b0;
                    end
                end else if (zc_rise) begin
                    if (!zc_seen) begin
                        zc_seen <= 1'b1;
                        zc_idx  <= k_cnt;
                        zc_cnt  <= 4'd1;
                    end else if (k_cnt == zc_idx) begin
                        if (zc_cnt != 4'hF) zc_cnt <= zc_cnt + 4'd1;
                    end else begin
                        zc_bad <= 1'b1;
                    end
                end
                WAIT:    if (line_cnt >= A_START) state <= ACTIVE;
                ACTIVE:  state <= ACTIVE;
                default: state <= SYNC;
            endcase
        end
    end

    // Window accumulate and output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_u    <= '0;
            acc_v    <= '0;
            win_act  <= 1'b0;
            u_out    <= '0;
            v_out    <= '0;
            uv_valid <= 1'b0;
            y_out    <= '0;
        end else begin
            uv_valid <= 1'b0;
            y_out    <= y_p0;
            if (demod_en) begin
                if (d == 4'd0) win_act <= 1'b1;
                if (d == 4'd0 || win_act) begin
                    acc_u <= acc_u_nxt;
                    acc_v <= acc_v_nxt;
                end
                if (d == K_LAST && win_act) begin
                    uv_valid <= 1'b1;
                    u_out    <= locked ? sat_out(acc_u_nxt) : '0;
                    v_out    <= locked ? sat_out(acc_v_nxt) : '0;
                end
            end else begin
                win_act <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        y_p0     <= y_in;
        c_s_prev <= c_s;
    end

endmodule

// File: tb/tb_yc_chroma_decoder.sv
// Directed bench for yc_chroma_decoder: drives whole video lines with burst and
// chroma patterns and checks lock status and demodulated U/V per line.
module tb_yc_chroma_decoder;

    logic              clk = 1'b0;
    logic              reset_n, hsync;
    logic        [7:0] y_in, c_in, y_out;
    logic signed [7:0] u_out, v_out;
    logic              uv_valid, locked;

    int checks   = 0;
    int failures = 0;

    int uv_cnt, uv_first, uv_prev, gap_err, u_min, u_max, v_min, v_max;
    int y_err, lk_pre, lk_post, uv_sync;

    localparam real PI = 3.14159265358979;

    always #5 clk = ~clk;

    yc_chroma_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hsync    (hsync),
        .y_in     (y_in),
        .c_in     (c_in),
        .y_out    (y_out),
        .u_out    (u_out),
        .v_out    (v_out),
        .uv_valid (uv_valid),
        .locked   (locked)
    );

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // mode 1: sine, mode 2: cosine, phase ph in samples of the 14-sample cycle
    function automatic int wave(input int mode, input int amp, input int ph, input int n);
        real th;
        th = 2.0 * PI * real'((n % 14) - ph) / 14.0;
        if (mode == 1) return 100 + rnd(real'(amp) * $sin(th));
        return 100 + rnd(real'(amp) * $cos(th));
    endfunction

    function automatic logic [7:0] ymap(input int n);
        return 8'((n * 7 + 3) & 255);
    endfunction

    // b_mode: 0 flat burst, 1 clean burst, 2 burst whose phase jumps mid-window
    task automatic run_line(input int b_mode, input int b_ph, input int a_mode, input int a_amp,
                            input int a_ph, input int stop_n, input int hs_cycles);
        uv_cnt = 0; uv_first = -1; uv_prev = -1; gap_err = 0; y_err = 0; uv_sync = 0;
        u_min = 999; u_max = -999; v_min = 999; v_max = -999; lk_pre = -1; lk_post = -1;
        for (int n = 0; n < stop_n; n++) begin
            int cv;
            hsync = 1'b0;
            y_in  = ymap(n);
            if (n >= 45 && n <= 175) begin
                if (b_mode == 0)      cv = 100;
                else if (b_mode == 1) cv = wave(1, 30, b_ph, n);
                else                  cv = wave(1, 30, (n < 110) ? b_ph : b_ph + 3, n);
            end else if (n >= 176) begin
                cv = wave(a_mode, a_amp, a_ph, n);
            end else begin
                cv = 100;
            end
            c_in = 8'(cv);
            @(posedge clk); #1;
            if (n == 40)  lk_pre  = int'(locked);
            if (n == 176) lk_post = int'(locked);
            if (n >= 1 && y_out !== ymap(n - 1)) y_err++;
            if (uv_valid === 1'b1) begin
                if (uv_prev >= 0 && n - uv_prev != 14) gap_err++;
                if (uv_first < 0) uv_first = n;
                uv_prev = n;
                uv_cnt++;
                if (int'(u_out) < u_min) u_min = int'(u_out);
                if (int'(u_out) > u_max) u_max = int'(u_out);
                if (int'(v_out) < v_min) v_min = int'(v_out);
                if (int'(v_out) > v_max) v_max = int'(v_out);
            end
        end
        for (int i = 0; i < hs_cycles; i++) begin
            hsync = 1'b1;
            c_in  = 8'd100;
            @(posedge clk); #1;
            if (uv_valid === 1'b1) uv_sync++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hsync = 1'b1; y_in = 8'h00; c_in = 8'd100;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (u_out !== 8'sd0) begin failures++; $display("FAIL reset_u got=%0d exp=0", u_out); end
        checks++; if (v_out !== 8'sd0) begin failures++; $display("FAIL reset_v got=%0d exp=0", v_out); end
        checks++; if (y_out !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_out); end
        checks++; if (uv_valid !== 1'b0) begin failures++; $display("FAIL reset_uv_valid got=%b exp=0", uv_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL post_reset_locked got=%b exp=0", locked); end
    endtask

    task automatic test_lock_u();
        run_line(1, 3, 1, 20, 3, 400, 10);
        checks++; if (lk_pre !== 0) begin failures++; $display("FAIL lockU_pre got=%0d exp=0", lk_pre); end
        checks++; if (lk_post !== 1) begin failures++; $display("FAIL lockU_post got=%0d exp=1", lk_post); end
        checks++; if (uv_cnt !== 15) begin failures++; $display("FAIL lockU_uv_cnt got=%0d exp=15", uv_cnt); end
        checks++; if (uv_first !== 198) begin failures++; $display("FAIL lockU_first got=%0d exp=198", uv_first); end
        checks++; if (gap_err !== 0) begin failures++; $display("FAIL lockU_gap got=%0d exp=0", gap_err); end
        checks++; if (u_min !== 34 || u_max !== 34) begin failures++; $display("FAIL lockU_u got=%0d..%0d exp=34", u_min, u_max); end
        checks++; if (v_min !== 0 || v_max !== 0) begin failures++; $display("FAIL lockU_v got=%0d..%0d exp=0", v_min, v_max); end
        checks++; if (y_err !== 0) begin failures++; $display("FAIL lockU_y_delay got=%0d errors exp=0", y_err); end
        checks++; if (uv_sync !== 0) begin failures++; $display("FAIL lockU_uv_in_sync got=%0d exp=0", uv_sync); end
    endtask

    task automatic test_demod_v();
        run_line(1, 3, 2, 20, 3, 400, 10);
        checks++; if (lk_post !== 1) begin failures++; $display("FAIL demodV_lock got=%0d exp=1", lk_post); end
        checks++; if (uv_cnt !== 15) begin failures++; $display("FAIL demodV_uv_cnt got=%0d exp=15", uv_cnt); end
        checks++; if (v_min !== 34 || v_max !== 34) begin failures++; $display("FAIL demodV_v got=%0d..%0d exp=34", v_min, v_max); end
        checks++; if (u_min !== 0 || u_max !== 0) begin failures++; $display("FAIL demodV_u got=%0d..%0d exp=0", u_min, u_max); end
    endtask

    task automatic test_saturation();
        run_line(1, 3, 1, 80, 3, 400, 10);
        checks++; if (u_min !== 127 || u_max !== 127) begin failures++; $display("FAIL satpos_u got=%0d..%0d exp=127", u_min, u_max); end
        checks++; if (v_min !== 0 || v_max !== 0) begin failures++; $display("FAIL satpos_v got=%0d..%0d exp=0", v_min, v_max); end
        run_line(1, 3, 1, -80, 3, 400, 10);
        checks++; if (u_min !== -128 || u_max !== -128) begin failures++; $display("FAIL satneg_u got=%0d..%0d exp=-128", u_min, u_max); end
        checks++; if (v_min !== 0 || v_max !== 0) begin failures++; $display("FAIL satneg_v got=%0d..%0d exp=0", v_min, v_max); end
    endtask

    task automatic test_no_burst();
        run_line(0, 3, 1, 20, 3, 400, 10);
        checks++; if (lk_pre !== 1) begin failures++; $display("FAIL noburst_pre got=%0d exp=1", lk_pre); end
        checks++; if (lk_post !== 0) begin failures++; $display("FAIL noburst_post got=%0d exp=0", lk_post); end
        checks++; if (uv_cnt !== 15) begin failures++; $display("FAIL noburst_uv_cnt got=%0d exp=15", uv_cnt); end
        checks++; if (u_min !== 0 || u_max !== 0 || v_min !== 0 || v_max !== 0) begin
            failures++; $display("FAIL noburst_uv got u=%0d..%0d v=%0d..%0d exp=0", u_min, u_max, v_min, v_max);
        end
    endtask

    task automatic test_relock_phase5();
        run_line(1, 5, 1, 20, 5, 400, 10);
        checks++; if (lk_post !== 1) begin failures++; $display("FAIL relock_lock got=%0d exp=1", lk_post); end
        checks++; if (uv_first !== 200) begin failures++; $display("FAIL relock_first got=%0d exp=200", uv_first); end
        checks++; if (u_min !== 34 || u_max !== 34) begin failures++; $display("FAIL relock_u got=%0d..%0d exp=34", u_min, u_max); end
        checks++; if (v_min !== 0 || v_max !== 0) begin failures++; $display("FAIL relock_v got=%0d..%0d exp=0", v_min, v_max); end
    endtask

    task automatic test_truncation();
        run_line(1, 5, 2, 20, 5, 221, 12);
        checks++; if (uv_cnt !== 2) begin failures++; $display("FAIL trunc_uv_cnt got=%0d exp=2", uv_cnt); end
        checks++; if (uv_sync !== 0) begin failures++; $display("FAIL trunc_uv_in_sync got=%0d exp=0", uv_sync); end
        checks++; if (v_out !== 8'sd34) begin failures++; $display("FAIL trunc_v_hold got=%0d exp=34", v_out); end
        checks++; if (u_out !== 8'sd0) begin failures++; $display("FAIL trunc_u_hold got=%0d exp=0", u_out); end
    endtask

    task automatic test_jitter();
        run_line(2, 3, 1, 20, 3, 400, 10);
        checks++; if (lk_pre !== 1) begin failures++; $display("FAIL jitter_pre got=%0d exp=1", lk_pre); end
        checks++; if (lk_post !== 0) begin failures++; $display("FAIL jitter_post got=%0d exp=0", lk_post); end
        checks++; if (u_min !== 0 || u_max !== 0) begin failures++; $display("FAIL jitter_u got=%0d..%0d exp=0", u_min, u_max); end
    endtask

    task automatic test_async_reset();
        run_line(1, 3, 1, 20, 3, 300, 0);
        checks++; if (locked !== 1'b1 || u_out !== 8'sd34) begin
            failures++; $display("FAIL midline_pre_reset got locked=%b u=%0d exp locked=1 u=34", locked, u_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (u_out !== 8'sd0 || v_out !== 8'sd0 || y_out !== 8'd0 || uv_valid !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got u=%0d v=%0d y=%0d uvv=%b lk=%b exp all 0", u_out, v_out, y_out, uv_valid, locked);
        end
        hsync = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        run_line(1, 3, 1, 20, 3, 400, 10);
        checks++; if (lk_pre !== 0) begin failures++; $display("FAIL after_reset_pre got=%0d exp=0", lk_pre); end
        checks++; if (lk_post !== 1) begin failures++; $display("FAIL after_reset_lock got=%0d exp=1", lk_post); end
        checks++; if (u_min !== 34 || u_max !== 34) begin failures++; $display("FAIL after_reset_u got=%0d..%0d exp=34", u_min, u_max); end
    endtask

    initial begin
        test_reset();
        test_lock_u();
        test_demod_v();
        test_saturation();
        test_no_burst();
        test_relock_phase5();
        test_truncation();
        test_jitter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
